// File: rtl/sprite_line_renderer.sv
// sprite_line_renderer: overlays one 16x16 1bpp sprite on a 640x480 scan.
// During each line's horizontal blanking it fetches the sprite ROM row for
// the next line into a line buffer. During active video it compares pixel_x
// against the shadowed sprite column.
// Optional feature macro: SPRITE_MIRROR_EN adds the sprite_flip input,
// which mirrors the sprite horizontally.
module sprite_line_renderer (
  input  logic        pixel_clk,
  input  logic        reset,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        video_enable,
  input  logic [9:0]  sprite_x,
  input  logic [9:0]  sprite_y,
`ifdef SPRITE_MIRROR_EN
  input  logic        sprite_flip,
`endif
  output logic [3:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic [11:0] color_data
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADDR    = 2'd1,
    CAPTURE = 2'd2,
    READY   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  shadow_x_q, shadow_x_d;
  logic [9:0]  shadow_y_q, shadow_y_d;
  logic        line_valid_q, line_valid_d;
  logic [15:0] line_buf_q, line_buf_d;
  logic [3:0]  rom_addr_q, rom_addr_d;
  logic [11:0] color_q, color_d;

  logic        latch_en;
  logic [9:0]  next_y;
  logic [10:0] row;
  logic        sprite_line;
  logic [10:0] col_full;
  logic        in_span;
  logic [3:0]  col;
  logic [3:0]  bit_idx;

  // The position is latched only at the start of vertical blanking so a frame never tears
  assign latch_en = (pixel_y == 10'd480) && (pixel_x == 10'd0);

  // The line being prepared is the one after the current line, wrapping from 524 to 0
  assign next_y      = (pixel_y == 10'd524) ? 10'd0 : pixel_y + 10'd1;
  assign row         = {1'b0, next_y} - {1'b0, shadow_y_q};
  assign sprite_line = (row[10:4] == 7'd0);

  // A negative difference lands in the upper half of the 11-bit range, so it never matches
  assign col_full = {1'b0, pixel_x} - {1'b0, shadow_x_q};
  assign in_span  = (col_full[10:4] == 7'd0);
  assign col      = col_full[3:0];

`ifdef SPRITE_MIRROR_EN
  logic flip_q, flip_d;

  // The mirror flag is shadowed together with the position
  always_comb begin
    flip_d = flip_q;
    if (latch_en) flip_d = sprite_flip;
  end

  // Mirror flag register
  always_ff @(posedge pixel_clk) begin
    if (reset) flip_q <= 1'b0;
    else       flip_q <= flip_d;
  end

  assign bit_idx = flip_q ? col : (4'd15 - col);
`else
  assign bit_idx = 4'd15 - col;
`endif

  // Shadow position update, captured once per frame
  always_comb begin
    shadow_x_d = shadow_x_q;
    shadow_y_d = shadow_y_q;
    if (latch_en) begin
      shadow_x_d = sprite_x;
      shadow_y_d = sprite_y;
    end
  end

  // Fetch sequencer: the address goes out in ADDR and the ROM answers in CAPTURE.
  // The buffer then stays stable until the next blanking interval.
  always_comb begin
    state_d      = state_q;
    line_valid_d = line_valid_q;
    line_buf_d   = line_buf_q;
    rom_addr_d   = rom_addr_q;
    unique case (state_q)
      IDLE: begin
        if (pixel_x == 10'd640) state_d = ADDR;
      end
      ADDR: begin
        rom_addr_d = row[3:0];
        if (sprite_line) begin
          state_d = CAPTURE;
        end else begin
          line_valid_d = 1'b0;
          state_d      = READY;
        end
      end
      CAPTURE: begin
        line_buf_d   = rom_data;
        line_valid_d = 1'b1;
        state_d      = READY;
      end
      READY: begin
        if (pixel_x == 10'd799) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The address is combinational in ADDR so the ROM data arrives in CAPTURE
  assign rom_addr = rom_addr_d;

  // Pixel decision, registered to give one cycle of latency to the VGA stage
  always_comb begin
    color_d = 12'd0;
    if (video_enable && line_valid_q && in_span && line_buf_q[bit_idx]) color_d = 12'd1;
  end

  assign color_data = color_q;

  // State and datapath registers with synchronous reset
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      state_q      <= IDLE;
      shadow_x_q   <= 10'd0;
      shadow_y_q   <= 10'd0;
      line_valid_q <= 1'b0;
      line_buf_q   <= 16'd0;
      rom_addr_q   <= 4'd0;
      color_q      <= 12'd0;
    end else begin
      state_q      <= state_d;
      shadow_x_q   <= shadow_x_d;
      shadow_y_q   <= shadow_y_d;
      line_valid_q <= line_valid_d;
      line_buf_q   <= line_buf_d;
      rom_addr_q   <= rom_addr_d;
      color_q      <= color_d;
    end
  end

endmodule

// File: tb/tb_sprite_line_renderer.sv
// tb_sprite_line_renderer: drives whole scanlines and skips uninteresting lines.
// Each pixel is compared with a reference model of the sprite rules.
// Define SPRITE_MIRROR_EN to also exercise the mirror feature.
module tb_sprite_line_renderer;

  logic        pixel_clk;
  logic        reset;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        video_enable;
  logic [9:0]  sprite_x;
  logic [9:0]  sprite_y;
  logic        sprite_flip;
  logic [3:0]  rom_addr;
  logic [15:0] rom_data;
  logic [11:0] color_data;

  logic [15:0] rom_mem [16];

  int checks;
  int errors;

  // reference model state
  int          m_sx;
  int          m_sy;
  bit          m_flip;
  bit          m_valid;
  logic [15:0] m_bits;
  logic [3:0]  m_rom_addr;

  sprite_line_renderer dut (
    .pixel_clk    (pixel_clk),
    .reset        (reset),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .video_enable (video_enable),
    .sprite_x     (sprite_x),
    .sprite_y     (sprite_y),
`ifdef SPRITE_MIRROR_EN
    .sprite_flip  (sprite_flip),
`endif
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .color_data   (color_data)
  );

  // sprite ROM: data one cycle after address
  always @(posedge pixel_clk) rom_data <= rom_mem[rom_addr];

  always #5 pixel_clk = ~pixel_clk;

  task automatic model_reset();
    m_sx = 0; m_sy = 0; m_flip = 0; m_valid = 0; m_bits = 16'd0; m_rom_addr = 4'd0;
  endtask

  task automatic fill_rom(input logic [15:0] v);
    for (int r = 0; r < 16; r++) rom_mem[r] = v;
  endtask

  // one full scanline; reset_x >= 0 pulses reset on that pixel
  task automatic run_line(input int y, input int reset_x, output int ones);
    ones = 0;
    for (int x = 0; x < 800; x++) begin
      int ny;
      int d;
      int c;
      bit ve;
      bit exp_on;
      ve = (x < 640) && (y < 480);
      pixel_x = 10'(x);
      pixel_y = 10'(y);
      video_enable = ve;
      reset = (x == reset_x);
      exp_on = 0;
      c = x - m_sx;
      if (ve && m_valid && c >= 0 && c < 16) exp_on = m_bits[m_flip ? c : 15 - c];
      if (x == reset_x) exp_on = 0;
      if (x == 641 && reset_x != 640 && reset_x != 641) begin
        ny = (y == 524) ? 0 : y + 1;
        d = ny - m_sy;
        m_rom_addr = 4'(d);
        m_valid = (d >= 0) && (d < 16);
        if (m_valid) m_bits = rom_mem[d];
        #1;
        checks++;
        if (rom_addr !== m_rom_addr) begin
          errors++;
          $display("[TB] FAIL rom_addr_fetch y=%0d got %0d want %0d", y, rom_addr, m_rom_addr);
        end
      end
      if (x == 700) begin
        #1;
        checks++;
        if (rom_addr !== m_rom_addr) begin
          errors++;
          $display("[TB] FAIL rom_addr_hold y=%0d got %0d want %0d", y, rom_addr, m_rom_addr);
        end
      end
      @(posedge pixel_clk);
      #1;
      checks++;
      if (color_data !== (exp_on ? 12'd1 : 12'd0)) begin
        errors++;
        $display("[TB] FAIL pixel x=%0d y=%0d got %0d want %0d", x, y, color_data, exp_on);
      end
      if (color_data == 12'd1) ones++;
      if (x == reset_x) model_reset();
      else if (y == 480 && x == 0) begin
        m_sx = int'(sprite_x);
        m_sy = int'(sprite_y);
`ifdef SPRITE_MIRROR_EN
        m_flip = sprite_flip;
`else
        m_flip = 0;
`endif
      end
    end
    reset = 0;
  endtask

  task automatic check_ones(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    int n;
    $display("[TB] test_reset");
    reset = 1; pixel_x = 10'd100; pixel_y = 10'd100; video_enable = 1;
    repeat (3) @(posedge pixel_clk);
    #1;
    checks++;
    if (color_data !== 12'd0) begin
      errors++;
      $display("[TB] FAIL reset_color got %0d want 0", color_data);
    end
    checks++;
    if (rom_addr !== 4'd0) begin
      errors++;
      $display("[TB] FAIL reset_rom_addr got %0d want 0", rom_addr);
    end
    model_reset();
    reset = 0;
    // position inputs are not used until the first vblank latch
    sprite_x = 10'd300; sprite_y = 10'd200;
    for (int r = 0; r < 16; r++) rom_mem[r] = 16'($urandom);
    run_line(524, -1, n);
    run_line(0, -1, n);
    check_ones("origin_line0_ones", n, $countones(rom_mem[0]));
    run_line(1, -1, n);
    check_ones("origin_line1_ones", n, $countones(rom_mem[1]));
  endtask

  task automatic test_basic();
    int n;
    $display("[TB] test_basic");
    fill_rom(16'h8001);
    sprite_x = 10'd100; sprite_y = 10'd50; sprite_flip = 0;
    run_line(480, -1, n);
    run_line(524, -1, n);
    for (int y = 49; y <= 66; y++) begin
      run_line(y, -1, n);
      check_ones($sformatf("basic_ones_y%0d", y), n, (y >= 50 && y <= 65) ? 2 : 0);
    end
  endtask

  task automatic test_no_tear();
    int n;
    $display("[TB] test_no_tear");
    sprite_y = 10'd200;
    run_line(49, -1, n);
    run_line(50, -1, n);
    check_ones("notear_old_frame", n, 2);
    run_line(300, -1, n);
    run_line(480, -1, n);
    run_line(524, -1, n);
    run_line(49, -1, n);
    run_line(50, -1, n);
    check_ones("notear_old_pos_gone", n, 0);
    run_line(199, -1, n);
    run_line(200, -1, n);
    check_ones("notear_new_pos", n, 2);
  endtask

  task automatic test_clip();
    int n;
    $display("[TB] test_clip");
    fill_rom(16'hFFFF);
    sprite_x = 10'd630; sprite_y = 10'd470;
    run_line(480, -1, n);
    run_line(524, -1, n);
    for (int y = 0; y <= 2; y++) begin
      run_line(y, -1, n);
      check_ones("clip_top_rows", n, 0);
    end
    for (int y = 469; y <= 479; y++) begin
      run_line(y, -1, n);
      check_ones($sformatf("clip_ones_y%0d", y), n, (y >= 470) ? 10 : 0);
    end
    run_line(480, -1, n);
    run_line(524, -1, n);
    run_line(0, -1, n);
    check_ones("clip_no_wrap_y0", n, 0);
  endtask

  task automatic test_random();
    int n;
    int sy;
    $display("[TB] test_random");
    for (int it = 0; it < 2; it++) begin
      for (int r = 0; r < 16; r++) rom_mem[r] = 16'($urandom);
      sprite_x = 10'($urandom_range(0, 639));
      sy = $urandom_range(0, 479);
      sprite_y = 10'(sy);
      sprite_flip = 1'($urandom);
      run_line(480, -1, n);
      run_line((sy == 0) ? 524 : sy - 1, -1, n);
      for (int y = sy; y <= sy + 3 && y < 480; y++) run_line(y, -1, n);
      for (int y = sy + 13; y <= sy + 16 && y < 480; y++) run_line(y, -1, n);
    end
    sprite_flip = 0;
  endtask

  task automatic test_reset_mid_fetch();
    int n;
    $display("[TB] test_reset_mid_fetch");
    fill_rom(16'h8001);
    sprite_x = 10'd100; sprite_y = 10'd50;
    run_line(480, -1, n);
    run_line(58, -1, n);
    run_line(59, 642, n);
    run_line(60, -1, n);
    check_ones("abort_line60", n, 0);
    run_line(61, -1, n);
    run_line(524, -1, n);
    run_line(0, -1, n);
    check_ones("after_abort_origin", n, 2);
  endtask

`ifdef SPRITE_MIRROR_EN
  task automatic test_mirror();
    int n;
    $display("[TB] test_mirror");
    fill_rom(16'h8000);
    sprite_x = 10'd200; sprite_y = 10'd100; sprite_flip = 1;
    run_line(480, -1, n);
    run_line(99, -1, n);
    run_line(100, -1, n);
    check_ones("mirror_on_ones", n, 1);
    sprite_flip = 0;
    run_line(480, -1, n);
    run_line(99, -1, n);
    run_line(100, -1, n);
    check_ones("mirror_off_ones", n, 1);
  endtask
`endif

  initial begin
    checks = 0; errors = 0;
    pixel_clk = 0; reset = 1; pixel_x = 0; pixel_y = 0; video_enable = 0;
    sprite_x = 0; sprite_y = 0; sprite_flip = 0;
    fill_rom(16'd0);
    model_reset();
    test_reset();
    test_basic();
    test_no_tear();
    test_clip();
    test_random();
    test_reset_mid_fetch();
`ifdef SPRITE_MIRROR_EN
    test_mirror();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
